// File: rtl/mw_pkg.sv
// Shared opcodes, extended sub-codes and sequencer states
// for the Microwire EEPROM controller.
package mw_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] OP_EXT   = 2'b00;

  localparam logic [1:0] EX_EWDS = 2'b00;
  localparam logic [1:0] EX_WRAL = 2'b01;
  localparam logic [1:0] EX_ERAL = 2'b10;
  localparam logic [1:0] EX_EWEN = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_OUT,
    SHIFT_IN,
    CS_LOW,
    POLL,
    DONE
  } state_t;

  function automatic logic has_data(
    input logic [1:0] op,
    input logic [1:0] sub
  );
    return op == OP_WRITE ||
      (op == OP_EXT && sub == EX_WRAL);
  endfunction

  function automatic logic is_prog(
    input logic [1:0] op,
    input logic [1:0] sub
  );
    return op == OP_WRITE || op == OP_ERASE ||
      (op == OP_EXT &&
       (sub == EX_WRAL || sub == EX_ERAL));
  endfunction

endpackage

// File: rtl/mw_sk_gen.sv
// SK divider: strobes every CLK_DIV clks while enabled and
// toggles SK on each strobe when toggling is allowed.
module mw_sk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tog,
  output logic sk,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_ONE = DW'(1);

  logic [DW-1:0] div;

  assign tick = en && div == D_MAX;
  assign rise = tick && tog && !sk;
  assign fall = tick && tog && sk;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div <= '0;
      sk  <= 1'b0;
    end else begin
      div <= tick ? '0 : div + D_ONE;
      if (!tog)
        sk <= 1'b0;
      else if (tick)
        sk <= !sk;
    end
  end

endmodule

// File: rtl/mw_eeprom_ctrl.sv
// 93Cxx Microwire sequencer: frames one command on CS/SK/DI,
// collects read data from DO and polls ready/busy after programming.
module mw_eeprom_ctrl
  import mw_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 16,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ee_cs,
  output logic              ee_sk,
  output logic              ee_di,
  input  logic              ee_do
);

  localparam int FW = 3 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FW + 1);
  localparam int PW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] N_HDR = CW'(3 + ADDR_W);
  localparam logic [CW-1:0] N_ALL = CW'(FW);
  localparam logic [CW-1:0] N_RD  = CW'(DATA_W + 1);
  localparam logic [CW-1:0] N_TCS = CW'(2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [PW-1:0] P_MAX = PW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  state_t            state_q;
  state_t            state_d;
  logic [FW-1:0]     sreg;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     pcnt;
  logic [1:0]        op_q;
  logic [1:0]        sub_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        sub_in;
  logic [DATA_W-1:0] wd_in;
  logic              sk_en;
  logic              sk_tog;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              last;

  assign sub_in    = cmd_addr[ADDR_W-1 -: 2];
  assign wd_in     = has_data(cmd_op, sub_in) ? cmd_wdata : '0;
  assign last      = fall && cnt == C_ONE;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;

  mw_sk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sk (
    .clk (clk),
    .rst (rst),
    .en  (sk_en),
    .tog (sk_tog),
    .sk  (ee_sk),
    .tick(tick),
    .rise(rise),
    .fall(fall)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ee_cs     = 1'b0;
    ee_di     = 1'b0;
    sk_en     = 1'b0;
    sk_tog    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_d = CS_SETUP;
      end
      CS_SETUP: begin
        ee_cs = 1'b1;
        ee_di = sreg[FW-1];
        sk_en = 1'b1;
        if (tick)
          state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        ee_cs  = 1'b1;
        ee_di  = sreg[FW-1];
        sk_en  = 1'b1;
        sk_tog = 1'b1;
        if (last) begin
          if (op_q == OP_READ)
            state_d = SHIFT_IN;
          else if (is_prog(op_q, sub_q))
            state_d = CS_LOW;
          else
            state_d = DONE;
        end
      end
      SHIFT_IN: begin
        ee_cs  = 1'b1;
        sk_en  = 1'b1;
        sk_tog = 1'b1;
        if (last)
          state_d = DONE;
      end
      CS_LOW: begin
        sk_en = 1'b1;
        if (tick && cnt == C_ONE)
          state_d = POLL;
      end
      POLL: begin
        ee_cs = 1'b1;
        if (ee_do || pcnt == P_MAX)
          state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt counts bits per shift phase, then SK half-periods of tCS
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      cnt     <= '0;
      pcnt    <= '0;
      op_q    <= '0;
      sub_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            sub_q <= sub_in;
            err_q <= 1'b0;
            pcnt  <= '0;
            sreg  <= {1'b1, cmd_op, cmd_addr, wd_in};
            cnt   <= has_data(cmd_op, sub_in) ? N_ALL : N_HDR;
          end
        end
        SHIFT_OUT: begin
          if (fall) begin
            sreg <= sreg << 1;
            if (cnt == C_ONE)
              cnt <= (op_q == OP_READ) ? N_RD : N_TCS;
            else
              cnt <= cnt - C_ONE;
          end
        end
        SHIFT_IN: begin
          if (rise) begin
            sreg <= {sreg[FW-2:0], ee_do};
            if (cnt == N_RD && ee_do)
              err_q <= 1'b1;
          end
          if (fall) begin
            if (cnt == C_ONE)
              rdata_q <= sreg[DATA_W-1:0];
            else
              cnt <= cnt - C_ONE;
          end
        end
        CS_LOW: begin
          if (tick)
            cnt <= cnt - C_ONE;
        end
        POLL: begin
          if (!ee_do) begin
            if (pcnt == P_MAX)
              err_q <= 1'b1;
            else
              pcnt <= pcnt + P_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mw_eeprom_ctrl.sv
// Bench for mw_eeprom_ctrl: behavioural 93C46 on the pins,
// reference memory for expectations, scoreboard monitor.
module tb_mw_eeprom_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        ee_cs;
  logic        ee_sk;
  logic        ee_di;
  logic        ee_do;

  mw_eeprom_ctrl #(
    .CLK_DIV(2),
    .ADDR_W(6),
    .DATA_W(16),
    .BUSY_TIMEOUT(200)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .ee_cs    (ee_cs),
    .ee_sk    (ee_sk),
    .ee_di    (ee_di),
    .ee_do    (ee_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural 93C46 ----------------
  logic [15:0] mem [64];
  bit          ewen = 0;
  int          busy = 0;
  int          busy_len = 0;
  bit          force_busy = 0;
  bit          force_dummy = 0;
  int          nrise = 0;
  logic [31:0] rx = '0;
  bit          reading = 0;
  logic [16:0] rd_word = '0;
  int          rd_pos = -1;
  logic        do_reg = 1'b0;
  int          last_n = 0;
  logic [31:0] last_rx = '0;

  assign ee_do = reading ? do_reg : !(force_busy || busy > 0);

  always @(posedge clk) if (busy > 0) busy--;

  always @(posedge ee_sk) begin
    if (ee_cs) begin
      rx = {rx[30:0], ee_di};
      nrise++;
      if (nrise == 9 && rx[8:6] == 3'b110) begin
        reading = 1;
        rd_word = {force_dummy, mem[rx[5:0]]};
        rd_pos  = 16;
      end
    end
  end

  always @(negedge ee_sk) begin
    if (reading && rd_pos >= 0) begin
      do_reg = rd_word[rd_pos];
      rd_pos--;
    end
  end

  task automatic program_op(input int kind, input logic [5:0] a,
                            input logic [15:0] d);
    if (!ewen) return;
    case (kind)
      0: mem[a] = d;
      1: mem[a] = 16'hFFFF;
      2: for (int i = 0; i < 64; i++) mem[i] = d;
      default: for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
    endcase
    busy = busy_len;
  endtask

  always @(negedge ee_cs) begin
    logic [8:0] h;
    if (nrise > 0) begin
      last_n  = nrise;
      last_rx = rx;
    end
    if (nrise == 9 || nrise == 25) begin
      h = 9'(rx >> (nrise - 9));
      if (h[8]) begin
        if (h[7:6] == 2'b01 && nrise == 25) program_op(0, h[5:0], rx[15:0]);
        if (h[7:6] == 2'b11 && nrise == 9) program_op(1, h[5:0], '0);
        if (h[7:6] == 2'b00) begin
          if (h[5:4] == 2'b11 && nrise == 9) ewen = 1;
          if (h[5:4] == 2'b00 && nrise == 9) ewen = 0;
          if (h[5:4] == 2'b01 && nrise == 25) program_op(2, '0, rx[15:0]);
          if (h[5:4] == 2'b10 && nrise == 9) program_op(3, '0, '0);
        end
      end
    end
    nrise   = 0;
    rx      = '0;
    reading = 0;
    rd_pos  = -1;
  end

  // ---------------- reference + scoreboard ----------------
  typedef struct {
    logic [8:0]  hdr;
    logic [15:0] data;
    logic [15:0] rdata;
    int          periods;
    bit          is_read;
    bit          has_d;
    bit          prog;
    bit          err;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] ref_mem [64];
  bit          ref_ewen = 0;

  logic pcs = 1'b0;
  bit   pvalid = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] sh;
    if (rst) begin
      pvalid = 0;
    end else begin
      if (pvalid) begin
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("cs_after_done", ee_cs, 0);
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_rsp: got rsp_valid expected none");
        end else begin
          e = sbq.pop_front();
          chk("rsp_err", rsp_err, e.err);
          if (e.is_read) begin
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("di_low_in_read", last_rx[16:0], 0);
          end
          chk("sk_periods", last_n, e.periods);
          sh = (last_n >= 9) ? (last_rx >> (last_n - 9)) : '0;
          chk("di_header", sh[8:0], e.hdr);
          if (e.has_d) chk("di_data", last_rx[15:0], e.data);
          if (e.prog) chk("tcs_ge4", (rise_cyc - fall_cyc) >= 4, 1);
          if (e.lat) chk("timeout_lat", cyc - rise_cyc, 200);
        end
      end
      pvalid = rsp_valid;
    end
    if (ee_cs && !pcs) rise_cyc = cyc;
    if (!ee_cs && pcs) fall_cyc = cyc;
    pcs = ee_cs;
  end

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp expected rsp");
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] a,
                       input logic [15:0] d, input bit abort);
    exp_t e;
    logic [1:0] sub;
    bool_wait: for (int i = 0; i < 200; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    sub       = a[5:4];
    e.is_read = (op == 2'b10);
    e.has_d   = (op == 2'b01) || (op == 2'b00 && sub == 2'b01);
    e.prog    = (op == 2'b01) || (op == 2'b11) ||
                (op == 2'b00 && (sub == 2'b01 || sub == 2'b10));
    e.periods = e.is_read ? 26 : (e.has_d ? 25 : 9);
    e.hdr     = {1'b1, op, a};
    e.data    = d;
    e.rdata   = ref_mem[a];
    e.err     = (e.is_read && force_dummy) || (e.prog && force_busy);
    e.lat     = e.prog && force_busy;
    if (!abort) begin
      if (op == 2'b00 && sub == 2'b11) ref_ewen = 1;
      if (op == 2'b00 && sub == 2'b00) ref_ewen = 0;
      if (e.prog && ref_ewen) begin
        if (op == 2'b01) ref_mem[a] = d;
        else if (op == 2'b11) ref_mem[a] = 16'hFFFF;
        else for (int i = 0; i < 64; i++)
          ref_mem[i] = (sub == 2'b01) ? d : 16'hFFFF;
      end
      sbq.push_back(e);
    end
    last_n = 0;
    @(negedge clk);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 6'($urandom);
    cmd_wdata = 16'($urandom);
    if (abort) begin
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (nrise >= 4) break;
      end
      chk("abort_reached_bit4", nrise >= 4, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_cs", ee_cs, 0);
      chk("abort_sk", ee_sk, 0);
      chk("abort_di", ee_di, 0);
      chk("abort_ready", cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle();
    end
  endtask

  initial begin
    logic [15:0] v;
    int r;
    for (int i = 0; i < 64; i++) begin
      v = 16'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[5] = 16'hA5C3;
    ref_mem[5] = 16'hA5C3;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", ee_cs, 0);
    chk("rst_sk", ee_sk, 0);
    chk("rst_di", ee_di, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b10, 6'h05, 16'h0, 0);
    issue(2'b00, 6'b110000, 16'h0, 0);
    chk("model_ewen", ewen, 1);
    busy_len = 100;
    issue(2'b01, 6'h3F, 16'h1234, 0);
    issue(2'b10, 6'h3F, 16'h0, 0);
    force_busy = 1;
    issue(2'b01, 6'h0A, 16'hBEEF, 0);
    force_busy = 0;
    force_dummy = 1;
    issue(2'b10, 6'h0A, 16'h0, 0);
    force_dummy = 0;
    issue(2'b01, 6'h11, 16'h5555, 1);
    issue(2'b10, 6'h05, 16'h0, 0);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      busy_len = $urandom_range(0, 60);
      force_dummy = ($urandom_range(0, 7) == 0);
      v = 16'($urandom);
      case (r)
        0, 1, 2: issue(2'b10, 6'($urandom), v, 0);
        3, 4:    issue(2'b01, 6'($urandom), v, 0);
        5:       issue(2'b11, 6'($urandom), v, 0);
        6:       issue(2'b00, {2'b11, 4'($urandom)}, v, 0);
        7:       issue(2'b00, {2'b00, 4'($urandom)}, v, 0);
        8:       issue(2'b00, {2'b01, 4'($urandom)}, v, 0);
        default: issue(2'b00, {2'b10, 4'($urandom)}, v, 0);
      endcase
      force_dummy = 0;
    end
    issue(2'b00, 6'b110000, 16'h0, 0);
    issue(2'b01, 6'h21, 16'hC0DE, 0);
    issue(2'b10, 6'h21, 16'h0, 0);
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
